muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the Execute stage, beside the single-cycle ALU.
- The pipeline is the initiator and this block is the responder: it accepts one operand pair plus funct3 over a valid/ready handshake and returns one 32-bit result over a second valid/ready handshake.
- It covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, which the single-cycle ALU cannot execute.

---
 rtl/muldiv_unit_pkg.sv | 27 ++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode, state and operand-signedness definitions for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 33 cycles accept-to-result (1 for div-by-zero/overflow),
// result held in DONE until out_ready; kill discards in-flight work, in_ready only in IDLE.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      funct3,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Out,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [2:0]          op_q, op_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;

  logic                accept, last;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_step, div_step, iter, prod_s;
  logic [XLEN-1:0]     quot, remd, final_res;

  assign accept = in_valid & in_ready & ~kill;
  assign last   = (cnt_q == CNT_W'(XLEN - 1));

  assign a_neg = signed_a(funct3) & A[XLEN-1];
  assign b_neg = signed_b(funct3) & B[XLEN-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign div_zero    = funct3[2] & (B == '0);
  assign div_ovf     = ((funct3 == MD_DIV) || (funct3 == MD_REM)) & (A == MIN_NEG) & (B == '1);
  assign special_res = div_zero ? (funct3[1] ? A : '1) : (funct3[1] ? '0 : MIN_NEG);

  // Multiply: low half holds the remaining multiplier bits, shifted out as the sum shifts in.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: {remainder, dividend/quotient}; a clear borrow bit means the trial subtract fits.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_step  = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                      acc_q[XLEN-2:0], ~div_diff[XLEN]};

  assign iter   = op_q[2] ? div_step : mul_step;
  assign prod_s = neg_res_q ? -iter : iter;
  assign quot   = neg_res_q ? -iter[XLEN-1:0] : iter[XLEN-1:0];
  assign remd   = neg_rem_q ? -iter[2*XLEN-1:XLEN] : iter[2*XLEN-1:XLEN];

  always_comb begin
    final_res = '0;
    if (op_q[2])              final_res = op_q[1] ? remd : quot;
    else if (op_q == MD_MUL)  final_res = prod_s[XLEN-1:0];
    else                      final_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = (div_zero | div_ovf) ? MD_DONE : MD_CALC;
      MD_CALC: if (last) state_d = MD_DONE;
      MD_DONE: if (out_ready) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (kill) state_d = MD_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == MD_IDLE) & ~rst;
    busy      = (state_q != MD_IDLE);
    out_valid = (state_q == MD_DONE);
    Out       = out_valid ? res_q : '0;
  end

  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    if (accept) begin
      op_d      = funct3;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      opnd_d    = funct3[2] ? b_mag : a_mag;
      acc_d     = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
      res_d     = (div_zero | div_ovf) ? special_res : '0;
      cnt_d     = '0;
    end else if (state_q == MD_CALC) begin
      acc_d = iter;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        res_d = final_res;
        cnt_d = '0;
      end
    end
    if (kill) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      res_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results/latency plus backpressure, kill and reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  funct3 = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .funct3(funct3), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns after the accepting edge; inputs are then scrambled.
  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    funct3   = f3;
    A        = a;
    B        = b;
    tick();
    in_valid = 1'b0;
    A        = 32'hDEADBEEF;
    B        = 32'h0000_0000;
    funct3   = ~f3;
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid is observed.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin : main
    int lat;
    int seen;
    vecs[0]  = '{"MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"MULH min*min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{"MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{"MULHSU -1*2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[4]  = '{"MULH 3*5",      3'b001, 32'd3,        32'd5,        32'h00000000, 33};
    vecs[5]  = '{"DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[6]  = '{"REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[7]  = '{"DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[8]  = '{"REMU 100/7",    3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[9]  = '{"DIV 7/-2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[10] = '{"REM 7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[11] = '{"DIVU 5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[12] = '{"REMU 5/0",      3'b111, 32'd5,        32'd0,        32'd5,        1};
    vecs[13] = '{"DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[14] = '{"REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[15] = '{"REM -7/0",      3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};

    #2;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst Out",       Out,            32'd0);
    check("rst in_ready",  32'(in_ready),  32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check({vecs[i].name, " Out"},     Out,      vecs[i].exp);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      tick();
      check({vecs[i].name, " idle after consume"}, 32'(busy), 32'd0);
    end

    // Backpressure: result held in DONE while out_ready is low.
    out_ready = 1'b0;
    issue("bp DIVU", 3'b101, 32'd100, 32'd7);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      check("bp Out",       Out,              32'd14);
      check("bp out_valid", 32'(out_valid),   32'd1);
      check("bp in_ready",  32'(in_ready),    32'd0);
      check("bp busy",      32'(busy),        32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp released busy",      32'(busy),      32'd0);
    check("bp released out_valid", 32'(out_valid), 32'd0);
    check("bp released Out",       Out,            32'd0);
    check("bp released in_ready",  32'(in_ready),  32'd1);

    // kill during the 10th CALC cycle.
    issue("kill MUL", 3'b000, 32'd5, 32'd6);
    for (int c = 1; c < 10; c++) tick();
    check("kill pre busy", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill busy",      32'(busy),      32'd0);
    check("kill out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("kill never valid", 32'(seen), 32'd0);
    issue("MUL 3*4", 3'b000, 32'd3, 32'd4);
    wait_valid(lat);
    check("MUL 3*4 Out",     Out,      32'd12);
    check("MUL 3*4 latency", 32'(lat), 32'd33);
    tick();

    // kill alongside in_valid in IDLE: nothing accepted.
    kill     = 1'b1;
    in_valid = 1'b1;
    funct3   = 3'b101;
    A        = 32'd5;
    B        = 32'd0;
    tick();
    kill     = 1'b0;
    in_valid = 1'b0;
    check("kill+in_valid busy", 32'(busy), 32'd0);
    tick();
    check("kill+in_valid out_valid", 32'(out_valid), 32'd0);

    // kill wins over out_ready in DONE.
    out_ready = 1'b0;
    issue("kill DONE", 3'b111, 32'd9, 32'd0);
    check("kill DONE out_valid", 32'(out_valid), 32'd1);
    kill      = 1'b1;
    out_ready = 1'b1;
    tick();
    kill = 1'b0;
    check("kill DONE cleared", 32'(out_valid), 32'd0);
    check("kill DONE busy",    32'(busy),      32'd0);

    // Asynchronous reset pulse mid-CALC.
    issue("rst DIV", 3'b100, 32'd100, 32'd3);
    for (int c = 0; c < 5; c++) tick();
    #2 rst = 1'b1;
    #1;
    check("async rst busy",      32'(busy),      32'd0);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst Out",       Out,            32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("after rst in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("after rst no stale valid", 32'(seen), 32'd0);
    issue("DIV 9/3", 3'b100, 32'd9, 32'd3);
    wait_valid(lat);
    check("DIV 9/3 Out",     Out,      32'd3);
    check("DIV 9/3 latency", 32'(lat), 32'd33);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
